// File: rtl/apuf_pkg.sv
// Shared definitions for the arbiter-PUF response sampler: FSM state
// encoding and the default sizing used when the top is instantiated bare.
package apuf_pkg;

    // Default number of arbiter channels (response bits).
    localparam int APUF_N_CH       = 8;
    // Default number of evaluations voted per response (odd).
    localparam int APUF_N_EVAL     = 7;
    // Default settle time after launch, in clk cycles (covers the synchroniser).
    localparam int APUF_SETTLE_CYC = 4;

    // Sampler FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } apuf_state_t;

endpackage : apuf_pkg

// File: rtl/apuf_sync2.sv
// One-bit two-flop synchroniser for an arbiter latch output. Both stages
// reset to 1, the idle level of the arbiters, so a freshly reset sampler
// never sees a spurious 0 before the chain has flushed.
module apuf_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic stage1_reg;
    logic stage2_reg;

    // Shift the asynchronous input through two flops every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_reg <= 1'b1;
            stage2_reg <= 1'b1;
        end else begin
            stage1_reg <= d;
            stage2_reg <= stage1_reg;
        end
    end

    assign q = stage2_reg;

endmodule : apuf_sync2

// File: rtl/apuf_resp_sampler.sv
// Multi-channel arbiter-PUF response sampler. Each run fires N_EVAL launch
// pulses, samples every synchronised arbiter output SETTLE_CYC cycles after
// each launch, counts the ones per channel, and publishes a majority-voted
// response word together with a per-bit "all samples agreed" flag.
module apuf_resp_sampler
    import apuf_pkg::*;
#(
    parameter int N_CH       = APUF_N_CH,
    parameter int N_EVAL     = APUF_N_EVAL,
    parameter int SETTLE_CYC = APUF_SETTLE_CYC,
    parameter int CNT_W      = $clog2(N_EVAL + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [N_CH-1:0] arb_in,
    output logic            launch,
    output logic            busy,
    output logic            done,
    output logic [N_CH-1:0] response,
    output logic [N_CH-1:0] stable
);

    // The wait counter only ever holds SETTLE_CYC-1 down to 0.
    localparam int WAIT_W = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
    // The eval index only ever holds 0 .. N_EVAL-1.
    localparam int IDX_W  = (N_EVAL > 1) ? $clog2(N_EVAL) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE_CYC - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_EVAL - 1);
    localparam logic [CNT_W-1:0]  HALF_CNT  = CNT_W'(N_EVAL / 2);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(N_EVAL);

    apuf_state_t                  state_reg;
    logic [WAIT_W-1:0]            wait_cnt_reg;
    logic [IDX_W-1:0]             eval_idx_reg;
    logic [N_CH-1:0][CNT_W-1:0]   cnt_reg;

    // Per-channel count including the sample being taken this cycle; the
    // vote is formed from this so the final SAMPLE is part of the result.
    logic [N_CH-1:0][CNT_W-1:0]   cnt_next;
    logic [N_CH-1:0]              sync_q;
    logic [N_CH-1:0]              resp_next;
    logic [N_CH-1:0]              stable_next;

    // Per-channel synchroniser, ones-accumulator and vote.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        apuf_sync2 u_sync (
            .clk (clk),
            .rst (rst),
            .d   (arb_in[gi]),
            .q   (sync_q[gi])
        );

        assign cnt_next[gi]    = cnt_reg[gi] + CNT_W'(sync_q[gi]);
        assign resp_next[gi]   = (cnt_next[gi] > HALF_CNT);
        assign stable_next[gi] = (cnt_next[gi] == '0) || (cnt_next[gi] == FULL_CNT);
    end

    // Sequencer: launch, settle, sample, repeat N_EVAL times, then publish.
    // All outputs are registered and change on the edge that enters the
    // state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            eval_idx_reg <= '0;
            cnt_reg      <= '0;
            launch       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            response     <= '0;
            stable       <= '0;
        end else begin
            launch <= 1'b0;
            done   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        cnt_reg      <= '0;
                        eval_idx_reg <= '0;
                        launch       <= 1'b1;
                        busy         <= 1'b1;
                        state_reg    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wait_cnt_reg <= WAIT_LOAD;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == '0) begin
                        state_reg <= ST_SAMPLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    cnt_reg <= cnt_next;
                    if (eval_idx_reg == LAST_IDX) begin
                        response  <= resp_next;
                        stable    <= stable_next;
                        done      <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        eval_idx_reg <= eval_idx_reg + 1'b1;
                        launch       <= 1'b1;
                        state_reg    <= ST_LAUNCH;
                    end
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : apuf_resp_sampler

// File: tb/tb_apuf_resp_sampler.sv
// Directed + randomised bench for apuf_resp_sampler (N_CH=4, N_EVAL=5,
// SETTLE_CYC=3). Each run holds one arb_in value per evaluation window and
// the expected vote is computed by counting ones across those windows.
module tb_apuf_resp_sampler;

    localparam int N_CH   = 4;
    localparam int N_EVAL = 5;
    localparam int SETTLE = 3;
    localparam int EV_CYC = SETTLE + 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N_CH-1:0] arb_in;
    logic            launch;
    logic            busy;
    logic            done;
    logic [N_CH-1:0] response;
    logic [N_CH-1:0] stable;

    int checks = 0;
    int errors = 0;
    int launches;
    logic [N_CH-1:0] win [N_EVAL];

    apuf_resp_sampler #(
        .N_CH       (N_CH),
        .N_EVAL     (N_EVAL),
        .SETTLE_CYC (SETTLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .arb_in   (arb_in),
        .launch   (launch),
        .busy     (busy),
        .done     (done),
        .response (response),
        .stable   (stable)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: majority and unanimity over the per-window values.
    function automatic logic [N_CH-1:0] ref_resp();
        logic [N_CH-1:0] r;
        for (int ch = 0; ch < N_CH; ch++) begin
            int ones = 0;
            for (int k = 0; k < N_EVAL; k++) ones += int'(win[k][ch]);
            r[ch] = (ones > N_EVAL / 2);
        end
        return r;
    endfunction

    function automatic logic [N_CH-1:0] ref_stable();
        logic [N_CH-1:0] r;
        for (int ch = 0; ch < N_CH; ch++) begin
            int ones = 0;
            for (int k = 0; k < N_EVAL; k++) ones += int'(win[k][ch]);
            r[ch] = (ones == 0) || (ones == N_EVAL);
        end
        return r;
    endfunction

    // One run from the current cycle: start is presented now and accepted
    // on the next edge. ignore_test pulses start mid-run and in the DONE
    // cycle; keep_start holds start high across DONE; abort_at >= 0 applies
    // rst during that cycle of the run.
    task automatic do_run(input string name, input bit ignore_test,
                          input bit keep_start, input int abort_at);
        logic [N_CH-1:0] exp_r;
        logic [N_CH-1:0] exp_s;
        exp_r    = ref_resp();
        exp_s    = ref_stable();
        launches = 0;
        start    = 1'b1;
        arb_in   = win[0];
        tick();
        if (!keep_start) start = 1'b0;
        for (int c = 0; c < N_EVAL * EV_CYC; c++) begin
            if (c % EV_CYC == 0) arb_in = win[c / EV_CYC];
            if (ignore_test && c == 6) start = 1'b1;
            if (ignore_test && c == 7) start = 1'b0;
            if (launch) launches++;
            check({name, ".launch"}, 32'(launch), 32'(c % EV_CYC == 0));
            check({name, ".busy"},   32'(busy),   32'd1);
            check({name, ".done_early"}, 32'(done), 32'd0);
            if (c == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check({name, ".abort_busy"},   32'(busy),     32'd0);
                check({name, ".abort_launch"}, 32'(launch),   32'd0);
                check({name, ".abort_resp"},   32'(response), 32'd0);
                check({name, ".abort_stable"}, 32'(stable),   32'd0);
                for (int w = 0; w < 40; w++) begin
                    tick();
                    check({name, ".abort_no_done"}, 32'(done), 32'd0);
                    check({name, ".abort_idle"},    32'(busy), 32'd0);
                end
                $display("run %s: aborted at cycle %0d", name, abort_at);
                return;
            end
            tick();
        end
        check({name, ".done"},     32'(done),     32'd1);
        check({name, ".busy_d"},   32'(busy),     32'd1);
        check({name, ".launches"}, 32'(launches), 32'(N_EVAL));
        check({name, ".response"}, 32'(response), 32'(exp_r));
        check({name, ".stable"},   32'(stable),   32'(exp_s));
        $display("run %s: response=%b stable=%b (exp %b %b)", name, response, stable, exp_r, exp_s);
        if (ignore_test) start = 1'b1;
        tick();
        check({name, ".done_pulse"}, 32'(done), 32'd0);
        check({name, ".busy_fall"},  32'(busy), 32'd0);
        if (keep_start) begin
            tick();
            check({name, ".restart_launch"}, 32'(launch), 32'd1);
            check({name, ".restart_busy"},   32'(busy),   32'd1);
            start = 1'b0;
            rst   = 1'b1;
            tick();
            rst   = 1'b0;
        end else begin
            start = 1'b0;
            for (int w = 0; w < 3; w++) begin
                tick();
                check({name, ".idle_launch"}, 32'(launch), 32'd0);
                check({name, ".idle_busy"},   32'(busy),   32'd0);
            end
        end
    endtask

    task automatic fill_const(input logic [N_CH-1:0] v);
        for (int k = 0; k < N_EVAL; k++) win[k] = v;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < N_EVAL; k++) win[k] = N_CH'($urandom);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        arb_in = '1;
        tick();
        tick();
        check("reset.launch",   32'(launch),   32'd0);
        check("reset.busy",     32'(busy),     32'd0);
        check("reset.done",     32'(done),     32'd0);
        check("reset.response", 32'(response), 32'd0);
        check("reset.stable",   32'(stable),   32'd0);

        // rst and start together: rst wins.
        start = 1'b1;
        tick();
        check("rst_start.busy",   32'(busy),   32'd0);
        check("rst_start.launch", 32'(launch), 32'd0);
        start = 1'b0;

        // arb_in=0 with start on the first post-reset cycle.
        rst = 1'b0;
        fill_const(4'b0000);
        do_run("post_reset_zero", 1'b0, 1'b0, -1);

        fill_const(4'b1010);
        do_run("const_1010", 1'b0, 1'b0, -1);

        win[0] = 4'b0001; win[1] = 4'b0001; win[2] = 4'b0000;
        win[3] = 4'b0000; win[4] = 4'b0001;
        do_run("ch0_11001", 1'b0, 1'b0, -1);

        win[0] = 4'b0000; win[1] = 4'b1000; win[2] = 4'b0000;
        win[3] = 4'b1000; win[4] = 4'b0000;
        do_run("ch3_01010", 1'b0, 1'b0, -1);

        fill_const(4'b1111);
        do_run("ignore_start", 1'b1, 1'b0, -1);
        fill_const(4'b0000);
        do_run("fresh_after_ignore", 1'b0, 1'b0, -1);

        for (int r = 0; r < 6; r++) begin
            fill_rand();
            do_run($sformatf("rand%0d", r), 1'b0, 1'b0, -1);
        end

        fill_const(4'b0110);
        do_run("prefill", 1'b0, 1'b0, -1);
        fill_rand();
        do_run("abort12", 1'b0, 1'b0, 12);

        fill_rand();
        do_run("held_start", 1'b0, 1'b1, -1);

        fill_rand();
        do_run("final_rand", 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_apuf_resp_sampler
